sdram_arbit: RTL
================

// Module: sdram_arbit
// PURPOSE
//  Command arbiter between the SDRAM init, auto-refresh, write and read engines and the SDRAM pins.
//  Downstream of sdram_init/sdram_aref: consumes init_end and ar_req/ar_end, issues ar_en, and muxes
//  the granted engine's cmd/bank/addr onto the device bus.
//  Fixed priority once initialised: auto-refresh > write > read. Exactly one grant active at a time.
// PARAMETERS
//  ADDR_W   13        SDRAM address width
//  BANK_W   2         bank address width
//  DATA_W   16        DQ width
//  CMD_NOP  4'b0111   {cs_n,ras_n,cas_n,we_n} driven while no engine owns the bus
// PORTS
//  arb_clk     in   1       system clock (100 MHz)
//  arb_rst_n   in   1       async active-low reset
//  init_end    in   1       init sequence done (level)
//  init_cmd    in   4       init engine command
//  init_bank   in   BANK_W  init engine bank
//  init_addr   in   ADDR_W  init engine address
//  ar_req      in   1       refresh request (level until granted)
//  ar_end      in   1       refresh done, 1-cycle pulse
//  ar_cmd      in   4       refresh engine command
//  ar_bank     in   BANK_W  refresh engine bank
//  ar_addr     in   ADDR_W  refresh engine address
//  wr_req      in   1       write burst request (level)
//  wr_end      in   1       write done, 1-cycle pulse
//  wr_cmd      in   4       write engine command
//  wr_bank     in   BANK_W  write engine bank
//  wr_addr     in   ADDR_W  write engine address
//  wr_dq_oe    in   1       write engine DQ drive enable
//  wr_dq       in   DATA_W  write data
//  rd_req      in   1       read burst request (level)
//  rd_end      in   1       read done, 1-cycle pulse
//  rd_cmd      in   4       read engine command
//  rd_bank     in   BANK_W  read engine bank
//  rd_addr     in   ADDR_W  read engine address
//  ar_en       out  1       refresh grant (registered)
//  wr_en       out  1       write grant (registered)
//  rd_en       out  1       read grant (registered)
//  sdram_cke   out  1       clock enable (registered)
//  sdram_cmd   out  4       {cs_n,ras_n,cas_n,we_n}
//  sdram_bank  out  BANK_W  bank address
//  sdram_addr  out  ADDR_W  address
//  sdram_dq_oe out  1       DQ output enable (tristate at top level)
//  sdram_dq_o  out  DATA_W  DQ output data
// BEHAVIOUR
//  - Reset: state=IDLE; ar_en/wr_en/rd_en=0; sdram_cke=0 (goes 1 on first clock after release).
//  - States, registered: IDLE -> ARBIT -> {AREF | WRITE | READ} -> ARBIT.
//    IDLE:  leave to ARBIT on the first cycle init_end=1. init_end is sampled only in IDLE and
//           is sticky thereafter.
//    ARBIT: if ar_req -> AREF; else if wr_req -> WRITE; else if rd_req -> READ; else stay.
//           Simultaneous requests resolve by priority in the same cycle.
//    AREF/WRITE/READ: hold until the matching *_end pulse, then return to ARBIT next cycle.
//           *_end pulses outside the matching state are ignored.
//           Requests arriving mid-operation wait; no preemption.
//  - Grant: x_en=1 exactly while state==X, registered. Req sampled at edge N gives en=1 from N+1.
//    End at edge M gives en=0 from M+1. Min 1 ARBIT cycle between grants.
//  - Bus mux, combinational on state:
//    IDLE: init_*.  AREF: ar_*.  WRITE: wr_*.  READ: rd_*.
//    ARBIT: CMD_NOP, bank all-ones, addr all-ones.
//  - sdram_dq_oe = wr_dq_oe in WRITE, else 0. sdram_dq_o = wr_dq always.
//  - Reset mid-operation: all grants drop immediately (async). FSM restarts at IDLE and waits for a new init_end.
//  - Illegal state encodings recover to IDLE.
// STRUCTURE
//  - Shared config include: command codes (NOP, PRE, AREF, ACT, WR, RD, MRS), state encodings,
//    ADDR_W/BANK_W/DATA_W, CYCLE.
//  - Single module; no sub-module. FSM and output mux are inline.
// TESTING
//  - Init only: rst released, init_end rises at t0 -> state ARBIT at t0+1 clk; sdram_cmd=4'b0111
//    until a request arrives.
//  - Refresh: ar_req=1 in ARBIT -> ar_en=1 next clk; sdram_cmd mirrors ar_cmd;
//    ar_end pulse -> ar_en=0 next clk, sdram_cmd=NOP.
//  - Priority: ar_req, wr_req and rd_req all rise in the same cycle -> order AREF, then WRITE,
//    then READ, each separated by one NOP cycle.
//  - Write DQ: in WRITE with wr_dq_oe=1 and wr_dq=16'hA5A5 -> sdram_dq_oe=1, sdram_dq_o=16'hA5A5;
//    in READ sdram_dq_oe=0.
//  - No preemption: ar_req rises mid-WRITE -> wr_en held until wr_end; ar_en=1 one ARBIT cycle later.
//  - Reset mid-READ: arb_rst_n low -> rd_en=0 async; state IDLE; bus follows init_*.
//    Stray rd_end in IDLE is ignored.

Source files
------------

// File: rtl/sdram_arbit_pkg.sv
// Shared SDRAM arbiter configuration: bus widths, command codes and FSM state encodings.
package sdram_arbit_pkg;

    localparam int SDR_ADDR_W = 13;
    localparam int SDR_BANK_W = 2;
    localparam int SDR_DATA_W = 16;
    localparam int CYCLE      = 10;   // system clock period in ns (100 MHz)

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] SDR_CMD_NOP  = 4'b0111;
    localparam logic [3:0] SDR_CMD_PRE  = 4'b0010;
    localparam logic [3:0] SDR_CMD_AREF = 4'b0001;
    localparam logic [3:0] SDR_CMD_ACT  = 4'b0011;
    localparam logic [3:0] SDR_CMD_WR   = 4'b0100;
    localparam logic [3:0] SDR_CMD_RD   = 4'b0101;
    localparam logic [3:0] SDR_CMD_MRS  = 4'b0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: waits for init, then grants refresh > write > read one at a time
// and muxes the owning engine's command/bank/address onto the device bus.
module sdram_arbit
    import sdram_arbit_pkg::*;
#(
    parameter int         ADDR_W  = SDR_ADDR_W,
    parameter int         BANK_W  = SDR_BANK_W,
    parameter int         DATA_W  = SDR_DATA_W,
    parameter logic [3:0] CMD_NOP = SDR_CMD_NOP
) (
    input  logic              arb_clk,
    input  logic              arb_rst_n,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [BANK_W-1:0] init_bank,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              ar_req,
    input  logic              ar_end,
    input  logic [3:0]        ar_cmd,
    input  logic [BANK_W-1:0] ar_bank,
    input  logic [ADDR_W-1:0] ar_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_dq_oe,
    input  logic [DATA_W-1:0] wr_dq,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BANK_W-1:0] rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              ar_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic [3:0]        sdram_cmd,
    output logic [BANK_W-1:0] sdram_bank,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              sdram_dq_oe,
    output logic [DATA_W-1:0] sdram_dq_o
);

    arb_state_t state;

    // Grants are registered alongside the state so each x_en is high exactly while state==X.
    always_ff @(posedge arb_clk or negedge arb_rst_n) begin
        if (!arb_rst_n) begin
            state     <= ST_IDLE;
            ar_en     <= 1'b0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            sdram_cke <= 1'b0;
        end else begin
            sdram_cke <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (init_end) state <= ST_ARBIT;
                end
                ST_ARBIT: begin
                    if (ar_req) begin
                        state <= ST_AREF;
                        ar_en <= 1'b1;
                    end else if (wr_req) begin
                        state <= ST_WRITE;
                        wr_en <= 1'b1;
                    end else if (rd_req) begin
                        state <= ST_READ;
                        rd_en <= 1'b1;
                    end
                end
                ST_AREF: begin
                    if (ar_end) begin
                        state <= ST_ARBIT;
                        ar_en <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (wr_end) begin
                        state <= ST_ARBIT;
                        wr_en <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (rd_end) begin
                        state <= ST_ARBIT;
                        rd_en <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ar_en <= 1'b0;
                    wr_en <= 1'b0;
                    rd_en <= 1'b0;
                end
            endcase
        end
    end

    // Bus mux follows the current owner; ARBIT and any stray encoding park the bus on NOP.
    always_comb begin
        sdram_cmd   = CMD_NOP;
        sdram_bank  = '1;
        sdram_addr  = '1;
        sdram_dq_oe = 1'b0;
        case (state)
            ST_IDLE: begin
                sdram_cmd  = init_cmd;
                sdram_bank = init_bank;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = ar_cmd;
                sdram_bank = ar_bank;
                sdram_addr = ar_addr;
            end
            ST_WRITE: begin
                sdram_cmd   = wr_cmd;
                sdram_bank  = wr_bank;
                sdram_addr  = wr_addr;
                sdram_dq_oe = wr_dq_oe;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_bank = rd_bank;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

    assign sdram_dq_o = wr_dq;

endmodule
